// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_sequencer
// Description : Instruction sequencer for the 8-bit calculator (ALU + 8x8 RF).
//               Optional macro: CALC_SEQ_STICKY_CARRY_EN (sticky carry flag).
// Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [22:0] In_instr,
    output logic        Res_valid,
    input  logic        Res_ready,
    output logic [7:0]  Res_data,
    output logic        Busy,
    output logic        Carry_flag,
    output logic        WEN,
    output logic [2:0]  RW,
    output logic [2:0]  RX,
    output logic [2:0]  RY,
    output logic [7:0]  DataIn,
    output logic        Sel,
    output logic [3:0]  Ctrl,
    input  logic [7:0]  busY,
    input  logic        Carry
);

    localparam int         c_AW     = $clog2(DEPTH);
    localparam logic [1:0] c_OP_REG  = 2'b00;
    localparam logic [1:0] c_OP_IMM  = 2'b01;
    localparam logic [1:0] c_OP_READ = 2'b10;
    localparam logic [1:0] c_OP_ITER = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ITER = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [22:0] r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [22:0] r_cur;
    logic [3:0]  r_count;
    logic        r_res_valid;
    logic [7:0]  r_res_data;
    logic        r_carry;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_done;
    logic        w_res_load;
    logic        w_res_ack;
    logic        w_write;
    logic [22:0] w_head;
    logic [1:0]  w_op;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push   = In_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_op     = r_cur[22:21];
    assign w_res_ack = r_res_valid && Res_ready;

    assign In_ready   = !w_full;
    assign Res_valid  = r_res_valid;
    assign Res_data   = r_res_data;
    assign Busy       = !w_empty || (r_state != S_IDLE);
    assign Carry_flag = r_carry;

    // Storage array carries no reset; the pointers alone define occupancy.
    always_ff @(posedge Clk) begin
        if (Rst_n && w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= In_instr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_res_load  = 1'b0;
        case (r_state)
            S_IDLE: w_pop = !w_empty;
            S_EXEC: begin
                if (w_op == c_OP_READ) begin
                    w_res_load  = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_done = 1'b1;
                end
            end
            S_ITER: w_done = (r_count == 4'd0);
            S_RESP: w_done = w_res_ack;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_done) begin
            w_pop = !w_empty;
            if (w_empty) begin
                w_state_nxt = S_IDLE;
            end
        end
        if (w_pop) begin
            w_state_nxt = (w_head[22:21] == c_OP_ITER) ? S_ITER : S_EXEC;
        end
    end

    // Calculator pins come only from registered state, never from the FIFO head.
    always_comb begin
        w_write = ((r_state == S_EXEC) && (w_op != c_OP_READ)) || (r_state == S_ITER);
        WEN     = 1'b0;
        RW      = 3'd0;
        RX      = 3'd0;
        RY      = 3'd0;
        DataIn  = 8'd0;
        Sel     = 1'b0;
        Ctrl    = 4'd0;
        if (w_write) begin
            WEN    = 1'b1;
            RW     = r_cur[16:14];
            RX     = r_cur[13:11];
            RY     = r_cur[10:8];
            Ctrl   = r_cur[20:17];
            Sel    = (w_op != c_OP_IMM);
            DataIn = (w_op == c_OP_IMM) ? r_cur[7:0] : 8'd0;
        end else if ((r_state == S_EXEC) && (w_op == c_OP_READ)) begin
            RY = r_cur[10:8];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cur       <= '0;
            r_count     <= 4'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'd0;
            r_carry     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cur    <= w_head;
                r_count  <= w_head[3:0];
            end else if ((r_state == S_ITER) && (r_count != 4'd0)) begin
                r_count <= r_count - 1'b1;
            end
            if (w_res_load) begin
                r_res_valid <= 1'b1;
                r_res_data  <= busY;
            end else if (w_res_ack) begin
                r_res_valid <= 1'b0;
            end
`ifdef CALC_SEQ_STICKY_CARRY_EN
            if (w_res_ack) begin
                r_carry <= 1'b0;
            end else if (WEN) begin
                r_carry <= r_carry | Carry;
            end
`else
            if (WEN) begin
                r_carry <= Carry;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Directed self-checking bench with a behavioural calculator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

    logic        Clk       = 1'b0;
    logic        Rst_n     = 1'b0;
    logic        In_valid  = 1'b0;
    logic [22:0] In_instr  = '0;
    logic        Res_ready = 1'b0;
    logic        In_ready;
    logic        Res_valid;
    logic [7:0]  Res_data;
    logic        Busy;
    logic        Carry_flag;
    logic        WEN;
    logic [2:0]  RW;
    logic [2:0]  RX;
    logic [2:0]  RY;
    logic [7:0]  DataIn;
    logic        Sel;
    logic [3:0]  Ctrl;
    logic [7:0]  busY;
    logic        Carry;

    int checks    = 0;
    int failures  = 0;
    int wen_total = 0;

    calc_sequencer #(.DEPTH(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_valid(In_valid), .In_ready(In_ready), .In_instr(In_instr),
        .Res_valid(Res_valid), .Res_ready(Res_ready), .Res_data(Res_data),
        .Busy(Busy), .Carry_flag(Carry_flag),
        .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl),
        .busY(busY), .Carry(Carry)
    );

    always #5 Clk = ~Clk;

    // Calculator model: ctrl 0 = pass X, ctrl 1 = X + Y with carry out.
    logic [7:0] rf [8] = '{default: 8'h00};
    logic [8:0] alu;
    always_comb begin
        alu = {1'b0, rf[RX]};
        if (Ctrl == 4'd1) alu = {1'b0, rf[RX]} + {1'b0, rf[RY]};
    end
    assign busY  = rf[RY];
    assign Carry = alu[8];
    always @(posedge Clk) begin
        if (WEN) rf[RW] <= Sel ? alu[7:0] : DataIn;
        if (WEN) wen_total <= wen_total + 1;
    end

    function automatic logic [22:0] mk(input logic [1:0] op, input logic [3:0] ctrl,
                                       input logic [2:0] rw, input logic [2:0] rx,
                                       input logic [2:0] ry, input logic [7:0] imm);
        return {op, ctrl, rw, rx, ry, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [22:0] ins);
        int n = 0;
        In_valid = 1'b1;
        In_instr = ins;
        while (!In_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            failures++;
            $error("FAIL push_timeout observed=In_ready_low expected=In_ready_high");
        end
        tick();
        In_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!Res_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            failures++;
            $error("FAIL res_timeout observed=Res_valid_low expected=Res_valid_high");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            failures++;
            $error("FAIL idle_timeout observed=Busy_high expected=Busy_low");
        end
    endtask

    task automatic ack();
        Res_ready = 1'b1;
        tick();
        Res_ready = 1'b0;
    endtask

    initial begin
        int w0;
        // Reset with an instruction offered
        In_valid = 1'b1;
        In_instr = mk(2'b01, 4'd0, 3'd3, 3'd0, 3'd0, 8'hAA);
        repeat (3) tick();
        chk("rst_in_ready", In_ready, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_wen", WEN, 0);
        chk("rst_res_valid", Res_valid, 0);
        chk("rst_carry_flag", Carry_flag, 0);
        In_valid = 1'b0;
        Rst_n    = 1'b1;
        tick();
        chk("no_push_in_reset", Busy, 0);

        // IMM 0x5A -> r3, then READ r3 pushed while the IMM is popped
        push(mk(2'b01, 4'd0, 3'd3, 3'd0, 3'd0, 8'h5A));
        chk("imm_wait_pop", WEN, 0);
        In_valid = 1'b1;
        In_instr = mk(2'b10, 4'd0, 3'd0, 3'd0, 3'd3, 8'h00);
        tick();
        In_valid = 1'b0;
        chk("imm_wen", WEN, 1);
        chk("imm_rw", RW, 3);
        chk("imm_datain", DataIn, 8'h5A);
        chk("imm_sel", Sel, 0);
        tick();
        chk("read_exec_wen", WEN, 0);
        chk("read_exec_ry", RY, 3);
        chk("read_exec_res_valid", Res_valid, 0);
        tick();
        chk("read_res_valid", Res_valid, 1);
        chk("read_res_data", Res_data, 8'h5A);
        ack();
        chk("read_ack_res_valid", Res_valid, 0);
        chk("read_ack_busy", Busy, 0);

        // ITER: r1 = r1 + r2 four times starting from 1
        w0 = wen_total;
        push(mk(2'b01, 4'd0, 3'd1, 3'd0, 3'd0, 8'h01));
        push(mk(2'b01, 4'd0, 3'd2, 3'd0, 3'd0, 8'h01));
        push(mk(2'b11, 4'd1, 3'd1, 3'd1, 3'd2, 8'h03));
        push(mk(2'b10, 4'd0, 3'd0, 3'd0, 3'd1, 8'h00));
        wait_res();
        chk("iter_wen_count", wen_total - w0, 6);
        chk("iter_result", Res_data, 8'h05);
        ack();

        // Fill FIFO while RESP holds, then drain back-to-back
        push(mk(2'b10, 4'd0, 3'd0, 3'd0, 3'd1, 8'h00));
        wait_res();
        chk("hold_res_data", Res_data, 8'h05);
        push(mk(2'b00, 4'd1, 3'd4, 3'd1, 3'd2, 8'h00));
        push(mk(2'b00, 4'd1, 3'd5, 3'd4, 3'd2, 8'h00));
        push(mk(2'b00, 4'd1, 3'd6, 3'd5, 3'd2, 8'h00));
        push(mk(2'b00, 4'd1, 3'd7, 3'd6, 3'd2, 8'h00));
        chk("fifo_full_in_ready", In_ready, 0);
        chk("fifo_full_wen", WEN, 0);
        In_valid  = 1'b1;
        In_instr  = mk(2'b01, 4'd0, 3'd0, 3'd0, 3'd0, 8'hEE);
        Res_ready = 1'b1;
        tick();
        Res_ready = 1'b0;
        In_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_wen", WEN, 1);
            tick();
        end
        chk("b2b_end_wen", WEN, 0);
        chk("b2b_end_busy", Busy, 0);

        // READ held for 5 cycles with an IMM queued behind it
        push(mk(2'b10, 4'd0, 3'd0, 3'd0, 3'd7, 8'h00));
        push(mk(2'b01, 4'd0, 3'd0, 3'd0, 3'd0, 8'h33));
        wait_res();
        for (int i = 0; i < 5; i++) begin
            chk("resp_hold_wen", WEN, 0);
            chk("resp_hold_data", Res_data, 8'h09);
            tick();
        end
        ack();
        chk("post_ack_wen", WEN, 1);
        chk("post_ack_rw", RW, 0);
        chk("post_ack_datain", DataIn, 8'h33);
        chk("post_ack_res_valid", Res_valid, 0);
        wait_idle();

        // Carry: 0xFF + 0x01 overflows, then 1 + 1 does not
        push(mk(2'b01, 4'd0, 3'd1, 3'd0, 3'd0, 8'hFF));
        push(mk(2'b00, 4'd1, 3'd3, 3'd1, 3'd2, 8'h00));
        wait_idle();
        chk("carry_after_overflow", Carry_flag, 1);
        push(mk(2'b00, 4'd1, 3'd4, 3'd2, 3'd2, 8'h00));
        push(mk(2'b10, 4'd0, 3'd0, 3'd0, 3'd3, 8'h00));
        wait_res();
        chk("overflow_sum", Res_data, 8'h00);
`ifdef CALC_SEQ_STICKY_CARRY_EN
        chk("carry_sticky_held", Carry_flag, 1);
`else
        chk("carry_follows_last", Carry_flag, 0);
`endif
        ack();
        chk("carry_after_ack", Carry_flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
